// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning block.
// Cycle constants assume a 27 MHz system clock.
package btn_pkg;

    // Debouncer FSM states
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_t;

    // 10 ms, 1 s and 250 ms at 27 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 270_000;
    localparam int DEF_LONG_CYCLES     = 27_000_000;
    localparam int DEF_REPEAT_CYCLES   = 6_750_000;

    // Width of a counter that must hold 0 .. max_count-1; never below one bit
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
// Both flops load RESET_VALUE while rst_n is low so the chain starts at a known level.
module btn_sync
    import btn_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the pad level through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronises and debounces an active-low pad,
// then produces a clean level plus single-cycle press, release and long-press
// strobes. Optional auto-repeat strobes while held are enabled by defining
// BTN_DEBOUNCE_REPEAT_EN; without it repeat_pulse is tied low.
// All strobes and btn_level are registered, so a strobe and its level change
// appear on the same clock edge.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    // Elaboration-time sanity checks on the timing parameters
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_CYCLES must be at least 1");
    end

    logic sync_q;
    logic s_btn;

    btn_state_t        state;
    btn_state_t        state_next;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_cnt_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              long_done;
    logic              long_done_next;
    logic              level_next;
    logic              press_next;
    logic              release_next;
    logic              long_next;

    // The pad idles high (released), so the chain resets to 1
    btn_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (sync_q)
    );

    assign s_btn = ~sync_q;

    // FSM, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_next;
            deb_cnt       <= deb_cnt_next;
            hold_cnt      <= hold_cnt_next;
            long_done     <= long_done_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            long_pulse    <= long_next;
        end
    end

    // Next-state logic: debounce both edges, time the hold, raise strobes
    always_comb begin
        state_next     = state;
        deb_cnt_next   = deb_cnt;
        hold_cnt_next  = hold_cnt;
        long_done_next = long_done;
        level_next     = btn_level;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;

        case (state)
            IDLE: begin
                if (s_btn) begin
                    state_next   = DEB_PRESS;
                    deb_cnt_next = '0;
                end
            end

            DEB_PRESS: begin
                if (!s_btn) begin
                    state_next = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next     = HELD;
                    press_next     = 1'b1;
                    level_next     = 1'b1;
                    hold_cnt_next  = '0;
                    long_done_next = 1'b0;
                end else begin
                    deb_cnt_next = deb_cnt + 1'b1;
                end
            end

            HELD: begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
                // long_done keeps a saturated hold_cnt from firing again after a bounce
                if ((hold_cnt == HOLD_LAST) && !long_done) begin
                    long_next      = 1'b1;
                    long_done_next = 1'b1;
                end
                if (!s_btn) begin
                    state_next   = DEB_RELEASE;
                    deb_cnt_next = '0;
                end
            end

            DEB_RELEASE: begin
                if (s_btn) begin
                    state_next = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    level_next   = 1'b0;
                end else begin
                    deb_cnt_next = deb_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int REP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;

    // Auto-repeat timer: runs in HELD once the long press fired, frozen during release debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else if ((state == HELD) && long_done) begin
            if (rep_cnt == REP_LAST) begin
                rep_cnt      <= '0;
                repeat_pulse <= 1'b1;
            end else begin
                rep_cnt      <= rep_cnt + 1'b1;
                repeat_pulse <= 1'b0;
            end
        end else if (state == DEB_RELEASE) begin
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
